// File: rtl/glom_byte_packer.sv
// rtl/glom_byte_packer.sv - packs glommed bytes into BYTES_PER_WORD-lane words with flush
module glom_byte_packer #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter bit LSB_FIRST      = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BYTE_W-1:0]                in_byte,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] out_word,
    output logic [3:0]                       out_count
);

    localparam int         WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam logic [3:0] FULL   = 4'(BYTES_PER_WORD);

    typedef enum logic {
        S_FILL,
        S_EMIT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          count;
    logic [3:0]          count_next;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   acc_next;
    logic [WORD_W-1:0]   word_next;
    logic [3:0]          ocount_next;
    logic [WORD_W-1:0]   acc_with_byte;
    logic [3:0]          lane;
    logic                in_xfer;
    logic                out_xfer;

    assign in_ready  = (state == S_FILL);
    assign out_valid = (state == S_EMIT);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // MSB-first packing fills from the top lane downward.
    assign lane = LSB_FIRST ? count : (FULL - 4'd1 - count);

    always_comb begin
        acc_with_byte = acc;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane == 4'(i)) begin
                acc_with_byte[i*BYTE_W +: BYTE_W] = in_byte;
            end
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        acc_next    = acc;
        word_next   = out_word;
        ocount_next = out_count;
        case (state)
            S_FILL: begin
                if (in_xfer) begin
                    acc_next   = acc_with_byte;
                    count_next = count + 4'd1;
                end
                // The byte is packed before the flush is considered, so a completing
                // byte plus flush yields exactly one full word.
                if (count_next == FULL) begin
                    state_next  = S_EMIT;
                    word_next   = acc_next;
                    ocount_next = FULL;
                end else if (flush && (count_next != 4'd0)) begin
                    state_next  = S_EMIT;
                    word_next   = acc_next;
                    ocount_next = count_next;
                end
            end
            S_EMIT: begin
                if (out_xfer) begin
                    state_next  = S_FILL;
                    count_next  = 4'd0;
                    acc_next    = '0;
                    word_next   = '0;
                    ocount_next = 4'd0;
                end
            end
            default: begin
                state_next  = S_FILL;
                count_next  = 4'd0;
                acc_next    = '0;
                word_next   = '0;
                ocount_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FILL;
            count     <= 4'd0;
            acc       <= '0;
            out_word  <= '0;
            out_count <= 4'd0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            acc       <= acc_next;
            out_word  <= word_next;
            out_count <= ocount_next;
        end
    end

endmodule
